strip_alloc_write: RTL
======================

// Module: strip_alloc_write
// PURPOSE
//  Upstream allocation stage of the HRMPP placement pipeline. Takes one program (height, width) per
//  handshake and selects a strip by first fit on the strip's height class. It updates the per-strip
//  occupied-width table and produces strip_ID / occupied_width / strike for write_index_pipereg.
//  Programs that fit nowhere are rejected as strikes and counted.
// PARAMETERS
//  NUM_STRIPS   14   strips in the canvas table (strip IDs 0..NUM_STRIPS-1)
//  STRIP_WIDTH  128  usable width of each strip, in units
//  CANVAS_H     128  total canvas height available for strips
//  CLASS_STEP   4    height quantum; class_h = ceil(h/CLASS_STEP)*CLASS_STEP
// PORTS
//  clk               in   1  system clock, rising edge
//  rst               in   1  asynchronous, active-high reset
//  flush             in   1  sync: clear table/canvas (new frame); does not clear strike count
//  in_valid          in   1  height_in/width_in valid
//  in_ready          out  1  block can accept; high only in IDLE and when flush=0
//  height_in         in   5  program height, 1..31
//  width_in          in   5  program width, 1..31
//  out_valid         out  1  one-cycle pulse: result fields valid
//  strip_id_out      out  4  allocated strip (0 on strike)
//  occupied_width_out out 8  strip occupied width after placement, counted from 1 (0 on strike)
//  base_y_out        out  8  y base of allocated strip (0 on strike)
//  strike_flag_out   out  1  high with out_valid when the program is rejected
//  strike_out        out  4  running reject count, saturating at 15
// BEHAVIOUR
//  Reset: every output 0 except in_ready=1. Table cleared: occ[]=0, cls[]=0, base[]=0. num_open=0,
//   used_h=0, strike count 0, FSM=IDLE. Reset mid-operation discards the in-flight program; no out_valid.
//  State: occ[i] 8b, cls[i] 6b, base[i] 8b; num_open 0..NUM_STRIPS (strips 0..num_open-1 open); used_h 8b.
//  FSM IDLE->SEARCH->WRITE->IDLE.
//  IDLE: in_valid&&in_ready at edge E latches h, w, class_h; idx=0; go to SEARCH.
//  SEARCH (one strip per cycle), at each edge:
//   - illegal input (h==0 or w==0): decide STRIKE now.
//   - idx<num_open and cls[idx]==class_h and occ[idx]+w<=STRIP_WIDTH (9-bit compare): HIT idx.
//   - idx<num_open otherwise: idx++.
//   - idx==num_open: OPEN if num_open<NUM_STRIPS and used_h+class_h<=CANVAS_H (9-bit); else STRIKE.
//  WRITE (one cycle, outputs registered at its edge):
//   - HIT: occ[idx]+=w.
//   - OPEN: occ[n]=w, cls[n]=class_h, base[n]=used_h, used_h+=class_h, num_open++ (n=num_open).
//   - STRIKE: table untouched; count=min(count+1,15); strike_flag_out=1; id/occ/base outputs 0.
//   - out_valid=1 for exactly one cycle; return to IDLE, so in_ready=1 in the out_valid cycle.
//  Latency: accept edge to out_valid = 2+j cycles (j = examined strips before decision:
//   HIT at idx j -> j; OPEN/STRIKE -> num_open; illegal -> 0). Max NUM_STRIPS+2.
//  strike_out always shows the current count; updated in the same cycle as strike_flag_out.
//  No downstream backpressure; downstream samples on out_valid.
//  flush: synchronous, priority over everything except rst. Clears table, num_open, used_h; FSM->IDLE.
//   Aborts any in-flight program (no out_valid). Forces in_ready=0 that cycle (no accept). Count kept.
//  Result fields hold their last value between pulses.
// TESTING
//  T1 reset: assert rst async mid-cycle -> all outputs 0 immediately, in_ready=1; release, idle stable.
//  T2 h=5,w=10 on empty table -> out_valid 2 cycles after accept; id=0, occ=10, base_y=0, flag=0.
//  T3 then h=7,w=20 -> id=0, occ=30, lat 2; then h=3,w=4 -> class 4, id=1, occ=4, base_y=8, lat 3.
//  T4 then h=8,w=31 x4 -> occ 61,92,123 on strip0; 4th (154>128) opens id=2, base_y=12, occ=31, lat 4.
//  T5 after flush: h=31,w=1 x4 -> strips 0..3, base 0/32/64/96; 5th h=1,w=1 (class 4, used 128)
//   -> strike_flag=1, strike_out=1, id=0, occ=0; 16 such rejects -> strike_out stays 15.
//  T6 w=0 -> strike, lat 2; flush during SEARCH -> no out_valid, in_ready=1 next cycle, next alloc id=0.

Source files
------------

// File: rtl/strip_alloc_write.sv
// First-fit strip allocator: searches open strips one per cycle for a matching height class
// with spare width, opens a new strip when none fits, and rejects (strikes) when the canvas is full.
module strip_alloc_write #(
  parameter int NUM_STRIPS  = 14,
  parameter int STRIP_WIDTH = 128,
  parameter int CANVAS_H    = 128,
  parameter int CLASS_STEP  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] height_in,
  input  logic [4:0] width_in,
  output logic       out_valid,
  output logic [3:0] strip_id_out,
  output logic [7:0] occupied_width_out,
  output logic [7:0] base_y_out,
  output logic       strike_flag_out,
  output logic [3:0] strike_out
);

  localparam int CNT_W = $clog2(NUM_STRIPS + 1);

  typedef enum logic [1:0] {IDLE, SEARCH, WRITE} state_t;
  typedef enum logic [1:0] {DEC_HIT, DEC_OPEN, DEC_STRIKE} dec_t;

  function automatic logic [5:0] class_of(input logic [4:0] h);
    logic [5:0] t;
    t = ((6'(h) + 6'(CLASS_STEP - 1)) / 6'(CLASS_STEP)) * 6'(CLASS_STEP);
    return t;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  state_t           state_q;
  dec_t             dec_q;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] num_open_q;
  logic [7:0]       used_h_q;
  logic [3:0]       strike_q;

  logic [7:0]       occ_q  [NUM_STRIPS];
  logic [5:0]       cls_q  [NUM_STRIPS];
  logic [7:0]       base_q [NUM_STRIPS];

  logic [4:0]       h_q;
  logic [4:0]       w_q;
  logic [5:0]       cls_h_q;

  logic             out_valid_q;
  logic [3:0]       id_out_q;
  logic [7:0]       occ_out_q;
  logic [7:0]       base_out_q;
  logic             flag_q;

  logic [7:0]       cur_occ;
  logic [5:0]       cur_cls;
  logic [7:0]       cur_base;
  logic [7:0]       hit_occ;
  logic             fit_w;
  logic             fit_h;
  logic             at_end;
  logic             illegal;

  always_comb begin
    cur_occ  = '0;
    cur_cls  = '0;
    cur_base = '0;
    for (int i = 0; i < NUM_STRIPS; i++) begin
      if (idx_q == CNT_W'(i)) begin
        cur_occ  = occ_q[i];
        cur_cls  = cls_q[i];
        cur_base = base_q[i];
      end
    end
  end

  // Fit checks are done one bit wider so a full strip/canvas cannot wrap around.
  assign hit_occ = cur_occ + 8'(w_q);
  assign fit_w   = ({1'b0, cur_occ} + 9'(w_q)) <= 9'(STRIP_WIDTH);
  assign fit_h   = ({1'b0, used_h_q} + 9'(cls_h_q)) <= 9'(CANVAS_H);
  assign at_end  = (idx_q == num_open_q);
  assign illegal = (h_q == 5'd0) || (w_q == 5'd0);

  assign in_ready = (state_q == IDLE) && !flush;

  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid && !flush) begin
      h_q     <= height_in;
      w_q     <= width_in;
      cls_h_q <= class_of(height_in);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dec_q       <= DEC_HIT;
      idx_q       <= '0;
      num_open_q  <= '0;
      used_h_q    <= '0;
      strike_q    <= '0;
      out_valid_q <= 1'b0;
      id_out_q    <= '0;
      occ_out_q   <= '0;
      base_out_q  <= '0;
      flag_q      <= 1'b0;
      for (int i = 0; i < NUM_STRIPS; i++) begin
        occ_q[i]  <= '0;
        cls_q[i]  <= '0;
        base_q[i] <= '0;
      end
    end else if (flush) begin
      // New frame: drop the table and any in-flight program, keep the reject count and result fields.
      state_q     <= IDLE;
      idx_q       <= '0;
      num_open_q  <= '0;
      used_h_q    <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NUM_STRIPS; i++) begin
        occ_q[i]  <= '0;
        cls_q[i]  <= '0;
        base_q[i] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            idx_q   <= '0;
            state_q <= SEARCH;
          end
        end
        SEARCH: begin
          if (illegal) begin
            dec_q   <= DEC_STRIKE;
            state_q <= WRITE;
          end else if (!at_end) begin
            if (cur_cls == cls_h_q && fit_w) begin
              dec_q   <= DEC_HIT;
              state_q <= WRITE;
            end else begin
              idx_q <= idx_q + CNT_W'(1);
            end
          end else if (num_open_q < CNT_W'(NUM_STRIPS) && fit_h) begin
            dec_q   <= DEC_OPEN;
            state_q <= WRITE;
          end else begin
            dec_q   <= DEC_STRIKE;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b1;
          case (dec_q)
            DEC_HIT: begin
              for (int i = 0; i < NUM_STRIPS; i++) begin
                if (idx_q == CNT_W'(i)) occ_q[i] <= hit_occ;
              end
              id_out_q   <= 4'(idx_q);
              occ_out_q  <= hit_occ;
              base_out_q <= cur_base;
              flag_q     <= 1'b0;
            end
            DEC_OPEN: begin
              // On an open the search stopped at idx == num_open, so idx names the new strip.
              for (int i = 0; i < NUM_STRIPS; i++) begin
                if (idx_q == CNT_W'(i)) begin
                  occ_q[i]  <= 8'(w_q);
                  cls_q[i]  <= cls_h_q;
                  base_q[i] <= used_h_q;
                end
              end
              used_h_q   <= used_h_q + 8'(cls_h_q);
              num_open_q <= num_open_q + CNT_W'(1);
              id_out_q   <= 4'(idx_q);
              occ_out_q  <= 8'(w_q);
              base_out_q <= used_h_q;
              flag_q     <= 1'b0;
            end
            default: begin
              strike_q   <= sat_inc(strike_q);
              id_out_q   <= '0;
              occ_out_q  <= '0;
              base_out_q <= '0;
              flag_q     <= 1'b1;
            end
          endcase
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid          = out_valid_q;
  assign strip_id_out       = id_out_q;
  assign occupied_width_out = occ_out_q;
  assign base_y_out         = base_out_q;
  assign strike_flag_out    = flag_q;
  assign strike_out         = strike_q;

endmodule
